// File: rtl/node_task_table_if.sv
// if_axi_light: AXI-lite bundle (AW, W, B, AR, R channels) shared by the
// control interconnect and the node task table.
//   master modport: drives addresses, write data and response-ready.
//   slave  modport: drives the ready signals and the B/R responses.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

interface if_axi_light;
    logic [`AXI_ADDR_WIDTH-1:0]   awaddr;
    logic                         awvalid;
    logic                         awready;
    logic [`AXI_DATA_WIDTH-1:0]   wdata;
    logic [`AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                         wvalid;
    logic                         wready;
    logic [1:0]                   bresp;
    logic                         bvalid;
    logic                         bready;
    logic [`AXI_ADDR_WIDTH-1:0]   araddr;
    logic                         arvalid;
    logic                         arready;
    logic [`AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                   rresp;
    logic                         rvalid;
    logic                         rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/node_task_table.sv
// node_task_table: one program-address slot per processing node.
// Nodes poll their slot over AXI-lite reads and report completion by
// writing 0; the scheduler loads new program addresses into empty slots.
// Ports:
//   clk, res      clock and asynchronous active-high reset
//   s_axi         AXI-lite slave (reads return slot, writes store slot)
//   assign_*      scheduler load request (valid/ready, node id, address)
//   busy          bit n set while slot n is nonzero
//   fin_valid/fin_node  one-cycle pulse when a node clears a nonzero slot
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module node_task_table #(
    parameter int NODES      = 32,
    parameter int INDEX_PROG = 7,
    parameter int PICO_MSB   = 6,
    parameter int PICO_LSB   = 2
) (
    input  logic                       clk,
    input  logic                       res,
    if_axi_light.slave                 s_axi,
    input  logic                       assign_valid,
    input  logic [4:0]                 assign_node,
    input  logic [`AXI_DATA_WIDTH-1:0] assign_addr,
    output logic                       assign_ready,
    output logic [NODES-1:0]           busy,
    output logic                       fin_valid,
    output logic [4:0]                 fin_node
);
    localparam int DW = `AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    // Bit n set when node id n exists; lets a 5-bit id be range-checked
    // without a comparison that is constant for NODES=32.
    localparam logic [63:0] NODE_MASK_WIDE = (64'd1 << NODES) - 64'd1;
    localparam logic [31:0] NODE_MASK      = NODE_MASK_WIDE[31:0];
    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [1:0]  RESP_SLVERR    = 2'b10;

    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} w_state_t;

    logic [DW-1:0] slot_reg [NODES];

    r_state_t      r_state_reg, r_state_next;
    logic [DW-1:0] rdata_reg;
    logic [1:0]    rresp_reg;

    w_state_t      w_state_reg, w_state_next;
    logic          aw_latched_reg, w_latched_reg;
    logic          aw_prog_reg;
    logic [4:0]    aw_id_reg;
    logic [DW-1:0] wdata_reg;
    logic [SW-1:0] wstrb_reg;
    logic [1:0]    bresp_reg;

    logic [4:0]    ar_id;
    logic          ar_legal;
    logic          ar_hs, aw_hs, w_hs;
    logic          commit_en, commit_legal;
    logic [DW-1:0] old_slot;
    logic          load_en;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{s_axi.awaddr, s_axi.araddr};

    // ---------------- read path ----------------
    assign ar_id    = s_axi.araddr[PICO_MSB:PICO_LSB];
    assign ar_legal = s_axi.araddr[INDEX_PROG] && NODE_MASK[ar_id];
    assign ar_hs    = (r_state_reg == R_IDLE) && s_axi.arvalid;

    always_comb begin
        r_state_next   = r_state_reg;
        s_axi.arready  = 1'b0;
        s_axi.rvalid   = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                s_axi.arready = 1'b1;
                if (s_axi.arvalid) r_state_next = R_RESP;
            end
            R_RESP: begin
                s_axi.rvalid = 1'b1;
                if (s_axi.rready) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state_reg <= R_IDLE;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            r_state_reg <= r_state_next;
            if (ar_hs) begin
                rdata_reg <= ar_legal ? slot_reg[ar_id] : '0;
                rresp_reg <= ar_legal ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign s_axi.rdata = rdata_reg;
    assign s_axi.rresp = rresp_reg;

    // ---------------- write path ----------------
    assign aw_hs = (w_state_reg == W_COLLECT) && !aw_latched_reg && s_axi.awvalid;
    assign w_hs  = (w_state_reg == W_COLLECT) && !w_latched_reg  && s_axi.wvalid;

    always_comb begin
        w_state_next  = w_state_reg;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        case (w_state_reg)
            W_COLLECT: begin
                s_axi.awready = !aw_latched_reg;
                s_axi.wready  = !w_latched_reg;
                // Count this cycle's handshakes so the commit follows the
                // later of AW/W by exactly one cycle.
                if ((aw_latched_reg || aw_hs) && (w_latched_reg || w_hs))
                    w_state_next = W_COMMIT;
            end
            W_COMMIT: w_state_next = W_RESP;
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) w_state_next = W_COLLECT;
            end
            default: w_state_next = W_COLLECT;
        endcase
    end

    assign commit_en    = (w_state_reg == W_COMMIT);
    assign commit_legal = aw_prog_reg && NODE_MASK[aw_id_reg] && (&wstrb_reg);
    assign old_slot     = slot_reg[aw_id_reg];

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            w_state_reg    <= W_COLLECT;
            aw_latched_reg <= 1'b0;
            w_latched_reg  <= 1'b0;
            aw_prog_reg    <= 1'b0;
            aw_id_reg      <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            bresp_reg      <= RESP_OKAY;
        end else begin
            w_state_reg <= w_state_next;
            if (aw_hs) begin
                aw_latched_reg <= 1'b1;
                aw_prog_reg    <= s_axi.awaddr[INDEX_PROG];
                aw_id_reg      <= s_axi.awaddr[PICO_MSB:PICO_LSB];
            end
            if (w_hs) begin
                w_latched_reg <= 1'b1;
                wdata_reg     <= s_axi.wdata;
                wstrb_reg     <= s_axi.wstrb;
            end
            if (commit_en)
                bresp_reg <= commit_legal ? RESP_OKAY : RESP_SLVERR;
            if (w_state_reg == W_RESP && s_axi.bready) begin
                aw_latched_reg <= 1'b0;
                w_latched_reg  <= 1'b0;
            end
        end
    end

    assign s_axi.bresp = bresp_reg;

    assign fin_valid = commit_en && NODE_MASK[aw_id_reg] &&
                       (old_slot != '0) && (wdata_reg == '0);
    assign fin_node  = fin_valid ? aw_id_reg : 5'd0;

    // ---------------- scheduler load ----------------
    // The committing slot is blocked for the commit cycle so a load can
    // never race a node write on the same slot.
    assign assign_ready = NODE_MASK[assign_node] && (slot_reg[assign_node] == '0) &&
                          !(commit_en && aw_id_reg == assign_node);
    assign load_en      = assign_valid && assign_ready;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < NODES; i++) slot_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NODES; i++) begin
                if (commit_en && commit_legal && aw_id_reg == 5'(i))
                    slot_reg[i] <= wdata_reg;
                else if (load_en && assign_node == 5'(i))
                    slot_reg[i] <= assign_addr;
            end
        end
    end

    for (genvar gi = 0; gi < NODES; gi++) begin : g_busy
        assign busy[gi] = |slot_reg[gi];
    end
endmodule

// File: tb/tb_node_task_table.sv
module tb_node_task_table;
    logic        clk = 1'b0;
    logic        res;
    logic        assign_valid;
    logic [4:0]  assign_node;
    logic [31:0] assign_addr;
    logic        assign_ready;
    logic [31:0] busy;
    logic        fin_valid;
    logic [4:0]  fin_node;

    always #5 clk = ~clk;

    if_axi_light axi();

    node_task_table dut (
        .clk          (clk),
        .res          (res),
        .s_axi        (axi.slave),
        .assign_valid (assign_valid),
        .assign_node  (assign_node),
        .assign_addr  (assign_addr),
        .assign_ready (assign_ready),
        .busy         (busy),
        .fin_valid    (fin_valid),
        .fin_node     (fin_node)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_slot [32];
    int          fin_count = 0;
    logic [4:0]  fin_last = '0;
    bit          commit_flag = 0;

    always @(negedge clk) begin
        if (fin_valid) begin
            fin_count++;
            fin_last = fin_node;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = (model_slot[i] != 0);
        return b;
    endfunction

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit got = 0;
        @(posedge clk); #1;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (axi.arready) got = 1;
            else begin @(posedge clk); #1; end
        end
        check("ar_handshake", 32'(got), 1);
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b1;
        @(negedge clk);
        check("r_latency", 32'(axi.rvalid), 1);
        data = axi.rdata;
        resp = axi.rresp;
        @(posedge clk); #1;
        axi.rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        @(posedge clk); #1;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            axi.awaddr  = addr;
            axi.wdata   = data;
            axi.wstrb   = strb;
            axi.awvalid = !aw_done && (c >= aw_dly);
            axi.wvalid  = !w_done && (c >= w_dly);
            @(negedge clk);
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
        end
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        check("aw_w_handshake", 32'(aw_done && w_done), 1);
        commit_flag = 1;
        @(negedge clk);
        check("b_early", 32'(axi.bvalid), 0);
        resp = 2'bxx;
        for (int k = 0; k <= b_dly; k++) begin
            @(posedge clk); #1;
            commit_flag = 0;
            if (k == b_dly) axi.bready = 1'b1;
            @(negedge clk);
            check("bvalid_hold", 32'(axi.bvalid), 1);
            check("awready_low", 32'(axi.awready), 0);
            check("wready_low", 32'(axi.wready), 0);
            resp = axi.bresp;
        end
        @(posedge clk); #1;
        axi.bready = 1'b0;
        @(negedge clk);
        check("aw_reopen", 32'(axi.awready && axi.wready), 1);
    endtask

    task automatic do_load(input logic [4:0] node, input logic [31:0] addr);
        bit exp_rdy = (model_slot[node] == 0);
        @(posedge clk); #1;
        assign_valid = 1'b1;
        assign_node  = node;
        assign_addr  = addr;
        @(negedge clk);
        check("assign_ready", 32'(assign_ready), 32'(exp_rdy));
        @(posedge clk); #1;
        assign_valid = 1'b0;
        if (exp_rdy) model_slot[node] = addr;
        $display("load node=%0d addr=%h ready=%0d", node, addr, exp_rdy);
    endtask

    task automatic do_read(input logic [31:0] addr);
        logic [31:0] d;
        logic [1:0]  r;
        logic [4:0]  id = addr[6:2];
        bit legal = addr[7];
        axi_read(addr, d, r);
        check("rdata", d, legal ? model_slot[id] : 32'h0);
        check("rresp", 32'(r), legal ? 32'h0 : 32'h2);
        $display("read addr=%h data=%h resp=%0d", addr, d, r);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] r;
        logic [4:0] id = addr[6:2];
        bit legal = addr[7] && (strb == 4'hF);
        bit exp_fin = (model_slot[id] != 0) && (data == 0);
        int fc0 = fin_count;
        axi_write(addr, data, strb, aw_dly, w_dly, b_dly, r);
        check("bresp", 32'(r), legal ? 32'h0 : 32'h2);
        check("fin_count", 32'(fin_count - fc0), 32'(exp_fin));
        if (exp_fin) check("fin_node", 32'(fin_last), 32'(id));
        if (legal) model_slot[id] = data;
        $display("write addr=%h data=%h strb=%h resp=%0d fin=%0d", addr, data, strb, r, exp_fin);
    endtask

    task automatic collide(input logic [31:0] wval);
        fork
            do_write(32'h80 | (5 << 2), wval, 4'hF, 0, 0, 0);
            begin
                wait (commit_flag);
                assign_valid = 1'b1;
                assign_node  = 5'd5;
                assign_addr  = 32'h0000_ABC0;
                @(negedge clk);
                check("coll_ready_commit", 32'(assign_ready), 0);
                @(posedge clk); #1;
                @(negedge clk);
                check("coll_ready_next", 32'(assign_ready), 32'(wval == 0));
                @(posedge clk); #1;
                assign_valid = 1'b0;
            end
        join
        if (wval == 0) model_slot[5] = 32'h0000_ABC0;
        $display("collide node=5 wval=%h", wval);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        for (int i = 0; i < 32; i++) model_slot[i] = '0;
        res = 1'b1;
        assign_valid = 0; assign_node = 0; assign_addr = 0;
        axi.awaddr = 0; axi.awvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wvalid = 0;
        axi.bready = 0; axi.araddr = 0; axi.arvalid = 0; axi.rready = 0;
        repeat (3) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        check("rst_arready", 32'(axi.arready), 1);
        check("rst_awready", 32'(axi.awready), 1);
        check("rst_wready", 32'(axi.wready), 1);
        check("rst_rvalid", 32'(axi.rvalid), 0);
        check("rst_bvalid", 32'(axi.bvalid), 0);
        check("rst_rdata", axi.rdata, 0);
        check("rst_rresp", 32'(axi.rresp), 0);
        check("rst_bresp", 32'(axi.bresp), 0);
        check("rst_busy", busy, 0);
        check("rst_fin_valid", 32'(fin_valid), 0);
        check("rst_fin_node", 32'(fin_node), 0);
        check("rst_assign_ready", 32'(assign_ready), 1);

        // Directed sequence
        do_read(32'h80 | (3 << 2));
        do_load(5'd3, 32'h0001_0000);
        do_read(32'h80 | (3 << 2));
        check("busy_after_load", busy, model_busy());
        do_load(5'd3, 32'h0002_0000);
        do_write(32'h80 | (3 << 2), 32'h0, 4'hF, 0, 0, 0);
        check("busy_after_clear", busy, model_busy());
        do_write(32'h80 | (3 << 2), 32'h0, 4'hF, 0, 0, 0);
        do_load(5'd3, 32'h0003_0000);
        do_write(32'h80 | (3 << 2), 32'h0, 4'hF, 3, 0, 4);
        do_read(32'h00 | (3 << 2));
        do_read(32'hFFFF_FF7C);
        do_load(5'd9, 32'h0000_9000);
        do_write(32'h80 | (9 << 2), 32'h1234_5678, 4'b0011, 0, 2, 1);
        do_read(32'h80 | (9 << 2));
        collide(32'h5555_0000);
        do_write(32'h80 | (5 << 2), 32'h0, 4'hF, 1, 0, 0);
        collide(32'h0);
        do_read(32'h80 | (5 << 2));
        check("busy_after_collide", busy, model_busy());

        // Reset in the middle of a read response
        @(posedge clk); #1;
        axi.araddr = 32'h80 | (5 << 2); axi.arvalid = 1'b1;
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        @(negedge clk);
        check("mid_rvalid_before", 32'(axi.rvalid), 1);
        #2 res = 1'b1;
        #1;
        check("mid_rvalid_reset", 32'(axi.rvalid), 0);
        check("mid_busy_reset", busy, 0);
        @(negedge clk);
        res = 1'b0;
        for (int i = 0; i < 32; i++) model_slot[i] = '0;
        $display("reset during read response");
        do_read(32'h80 | (5 << 2));

        // Randomized traffic against the slot-array model
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 2))
                0: do_load(5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
                1: begin
                    a = $urandom;
                    a[7] = ($urandom_range(0, 3) != 0);
                    do_read(a);
                end
                default: begin
                    a = $urandom;
                    a[7] = ($urandom_range(0, 3) != 0);
                    d = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
                    s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
                    do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                end
            endcase
            check("busy_rand", busy, model_busy());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/node_task_table.md
# node_task_table

Control-side AXI-lite slave holding one program-address slot per processing node, serving the polling read and completion write issued by each node's self-awareness master. A scheduler port loads a nonzero program address into an empty slot. A node read returns its slot; a node write stores the write data, and writing 0 marks the task finished. The block sits behind the interconnect's control region, directly downstream of every node's polling master.

## Interface
- NODES, 32: number of slots; 1..32, since the node id field is 5 bits.
- INDEX_PROG, 7: address bit that must be 1 to select the program slot region.
- PICO_MSB / PICO_LSB, 6 / 2: address bit range holding the node id.
- clk  input  1  system clock, rising edge.
- res  input  1  asynchronous, active-high reset.
- s_axi  if_axi_light.slave  `AXI_ADDR_WIDTH / `AXI_DATA_WIDTH  AXI-lite slave port (AW, W, B, AR, R channels).
- assign_valid  input  1  scheduler requests a slot load.
- assign_node  input  5  target node id.
- assign_addr  input  `AXI_DATA_WIDTH  program base address.
- assign_ready  output  1  load accepted when high together with assign_valid.
- busy  output  NODES  bit n is high when slot n is nonzero.
- fin_valid  output  1  one-cycle pulse: a node cleared a nonzero slot.
- fin_node  output  5  id of the node that cleared its slot; valid while fin_valid is high.

## Operation
- Decode: id = addr[PICO_MSB:PICO_LSB]. Access is legal when addr[INDEX_PROG]=1 and id<NODES. All other address bits are ignored.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: arready=1. On an AR handshake, latch rdata (slot[id] if legal, else 0) and rresp (OKAY=2'b00 if legal, else SLVERR=2'b10), then go to R_RESP.
  - R_RESP: rvalid=1 and arready=0. On rready, go to R_IDLE.
- Write FSM states: W_COLLECT, W_COMMIT, W_RESP.
  - W_COLLECT: AW and W are accepted independently. awready is high while no AW is latched; wready is high while no W is latched. When both are latched, go to W_COMMIT.
  - W_COMMIT (one cycle):
    - Legal address and wstrb all ones: slot[id] <= wdata, bresp = OKAY.
    - Otherwise: no update, bresp = SLVERR.
    - If the old slot was nonzero and wdata=0: pulse fin_valid with fin_node=id.
    - Go to W_RESP.
  - W_RESP: bvalid=1, awready=0, wready=0. On bready, clear both latches and go to W_COLLECT.
- Scheduler load:
  - assign_ready = (assign_node<NODES) && slot[assign_node]==0 && !(in W_COMMIT && id==assign_node).
  - On assign_valid && assign_ready: slot[assign_node] <= assign_addr.
  - assign_addr=0 is accepted but leaves the slot at 0.
- assign_node≥NODES: assign_ready=0 permanently for that request. Driving such a request is a scheduler bug.
- busy is derived directly from the slot registers.

## Timing
- Reset (async assert, released synchronously to clk):
  - All slots = 0; both FSMs idle.
  - arready=1, awready=1, wready=1.
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
  - assign_ready reflects the empty slots; busy=0; fin_valid=0; fin_node=0.
- Reset asserted mid-transaction aborts it: the pending R/B response is dropped and latches are cleared.
- Read latency: AR handshake at cycle t gives rvalid at t+1, carrying the slot value sampled at t. rvalid holds until rready.
- Write latency: the later of the AW/W handshakes at t gives the commit at t+1 and bvalid at t+2. AW and W may arrive in the same cycle or in either order.
- Read and write FSMs run concurrently.
- A load and a commit never hit the same slot in one cycle; the commit wins and assign_ready drops for that cycle.
- A load at cycle t is visible to a read whose AR handshake occurs at t+1 or later. A read with AR handshake at t sees the pre-load value.
- A commit at t is visible to an AR handshake at t+1 or later.
- fin_valid is high exactly in the commit cycle. busy updates the cycle after a load or commit.

## Test plan
- Reset, then read node 3 at addr 0x80|(3<<2) -> rdata=0, rresp=OKAY, busy=0.
- Load node 3 with 0x0001_0000, then read node 3 -> rdata=0x0001_0000, busy[3]=1. A second load to node 3 sees assign_ready=0 until the slot is cleared.
- Write 0 to node 3 -> bresp=OKAY, fin_valid pulses once with fin_node=3, busy[3]=0. A repeat write of 0 produces no fin_valid.
- W presented 3 cycles before AW, with bready held low for 4 cycles -> exactly one commit, bvalid held stable throughout, and awready/wready low until bready.
- Read with addr bit 7=0, or id≥NODES -> rdata=0, rresp=SLVERR. Write with wstrb=4'b0011 -> bresp=SLVERR and the slot is unchanged.
- Collisions and reset:
  - Assign to node 5 in the same cycle as a write commit to node 5 -> assign_ready=0, the write value is kept, and the load is accepted the next cycle only if the written value was 0.
  - res asserted while rvalid=1 -> rvalid=0 immediately and all slots=0.
